// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: passes ALU results to WB and runs a req/ack data-memory access.
// Optional watchdog abort of hung accesses is enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned IR_W    = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic [IR_W-1:0]   mem_ir,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [DATA_W-1:0] reg_C,
    input  logic [DATA_W-1:0] smdr1,
    input  logic [DATA_W-1:0] d_rdata,
    input  logic              d_ack,
    output logic [IR_W-1:0]   wb_ir,
    output logic [DATA_W-1:0] reg_C1,
    output logic [ADDR_W-1:0] d_addr,
    output logic [DATA_W-1:0] d_wdata,
    output logic              d_we,
    output logic              d_req,
    output logic              stall,
    output logic              err
);

    if (ADDR_W > DATA_W || TIMEOUT < 2) begin : g_param_check
        $error("mem_access_stage: needs ADDR_W <= DATA_W and TIMEOUT >= 2");
    end

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [IR_W-1:0]   wb_ir_q, wb_ir_d;
    logic [DATA_W-1:0] reg_c1_q, reg_c1_d;
    logic [ADDR_W-1:0] d_addr_q, d_addr_d;
    logic [DATA_W-1:0] d_wdata_q, d_wdata_d;
    logic              d_we_q, d_we_d;
    logic              d_req_q, d_req_d;
    logic              access;
    logic              abort;

    assign access = run & (is_load | is_store);

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    // Abort takes priority over a coincident ack.
    assign abort = (state_q == StWait) && (wd_q == WdLast);
    assign err_d = err_q | abort;

    always_comb begin
        wd_d = wd_q;
        if (state_q == StWait) begin
            if (abort || d_ack) begin
                wd_d = '0;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        wb_ir_d   = wb_ir_q;
        reg_c1_d  = reg_c1_q;
        d_addr_d  = d_addr_q;
        d_wdata_d = d_wdata_q;
        d_we_d    = d_we_q;
        d_req_d   = d_req_q;
        case (state_q)
            StIdle: begin
                if (access) begin
                    state_d   = StWait;
                    d_req_d   = 1'b1;
                    d_addr_d  = reg_C[ADDR_W-1:0];
                    d_wdata_d = smdr1;
                    d_we_d    = is_store;
                    wb_ir_d   = '0;
                end else if (run) begin
                    wb_ir_d  = mem_ir;
                    reg_c1_d = reg_C;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                    d_req_d = 1'b0;
                    d_we_d  = 1'b0;
                    wb_ir_d = '0;
                end else if (d_ack) begin
                    state_d  = StIdle;
                    wb_ir_d  = mem_ir;
                    // d_we_q still records whether the access in flight is a store.
                    reg_c1_d = d_we_q ? reg_C : d_rdata;
                    d_req_d  = 1'b0;
                    d_we_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            wb_ir_q   <= '0;
            reg_c1_q  <= '0;
            d_addr_q  <= '0;
            d_wdata_q <= '0;
            d_we_q    <= 1'b0;
            d_req_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_ir_q   <= wb_ir_d;
            reg_c1_q  <= reg_c1_d;
            d_addr_q  <= d_addr_d;
            d_wdata_q <= d_wdata_d;
            d_we_q    <= d_we_d;
            d_req_q   <= d_req_d;
        end
    end

    assign stall   = ((state_q == StIdle) && access) || ((state_q == StWait) && !d_ack && !abort);
    assign wb_ir   = wb_ir_q;
    assign reg_C1  = reg_c1_q;
    assign d_addr  = d_addr_q;
    assign d_wdata = d_wdata_q;
    assign d_we    = d_we_q;
    assign d_req   = d_req_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random traffic checked against a
// transaction-level model every cycle. Timeout scenario runs when MEM_TIMEOUT_EN is defined.
module tb_mem_access_stage;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int IW = 16;
    localparam int TO = 8;
`ifdef MEM_TIMEOUT_EN
    localparam bit ToEn = 1'b1;
`else
    localparam bit ToEn = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          run = 1'b0, is_load = 1'b0, is_store = 1'b0, d_ack = 1'b0;
    logic [IW-1:0] mem_ir = '0;
    logic [DW-1:0] reg_C = '0, smdr1 = '0, d_rdata = '0;
    logic [IW-1:0] wb_ir;
    logic [DW-1:0] reg_C1, d_wdata;
    logic [AW-1:0] d_addr;
    logic          d_we, d_req, stall, err;

    int n_checks = 0;
    int n_errors = 0;
    int n_stall  = 0;
    logic last_stall = 1'b0;

    mem_access_stage #(.DATA_W(DW), .ADDR_W(AW), .IR_W(IW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .run(run), .mem_ir(mem_ir), .is_load(is_load),
        .is_store(is_store), .reg_C(reg_C), .smdr1(smdr1), .d_rdata(d_rdata), .d_ack(d_ack),
        .wb_ir(wb_ir), .reg_C1(reg_C1), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
        .d_req(d_req), .stall(stall), .err(err)
    );

    always #5 clock = ~clock;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Transaction-level model: a pending access (busy) plus the values WB and memory must see.
    logic          m_busy = 1'b0, m_ld = 1'b0, m_we = 1'b0, m_req = 1'b0, m_err = 1'b0;
    logic [IW-1:0] m_wb = '0;
    logic [DW-1:0] m_c1 = '0, m_wdata = '0;
    logic [AW-1:0] m_addr = '0;
    int            m_wd = 0;

    function automatic bit hung();
        return ToEn && m_busy && (m_wd == TO - 1);
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_ld <= 1'b0; m_we <= 1'b0; m_req <= 1'b0; m_err <= 1'b0;
            m_wb <= '0; m_c1 <= '0; m_wdata <= '0; m_addr <= '0; m_wd <= 0;
        end else if (!m_busy) begin
            if (run && (is_load || is_store)) begin
                m_busy <= 1'b1; m_ld <= is_load; m_req <= 1'b1; m_we <= is_store;
                m_addr <= reg_C[AW-1:0]; m_wdata <= smdr1; m_wb <= '0;
            end else if (run) begin
                m_wb <= mem_ir; m_c1 <= reg_C;
            end
        end else if (hung()) begin
            m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_err <= 1'b1; m_wb <= '0; m_wd <= 0;
        end else if (d_ack) begin
            m_busy <= 1'b0; m_req <= 1'b0; m_we <= 1'b0; m_wd <= 0;
            m_wb <= mem_ir; m_c1 <= m_ld ? d_rdata : reg_C;
        end else begin
            m_wd <= m_wd + 1;
        end
    end

    always @(negedge clock) begin
        check("wb_ir", 32'(wb_ir), 32'(m_wb));
        check("reg_C1", 32'(reg_C1), 32'(m_c1));
        check("d_req", 32'(d_req), 32'(m_req));
        check("d_we", 32'(d_we), 32'(m_we));
        check("err", 32'(err), 32'(m_err));
        check("stall", 32'(stall), 32'((!m_busy && run && (is_load || is_store)) ||
                                       (m_busy && !d_ack && !hung())));
        if (m_req) begin
            check("d_addr", 32'(d_addr), 32'(m_addr));
            check("d_wdata", 32'(d_wdata), 32'(m_wdata));
        end
    end

    task automatic tick();
        @(negedge clock);
        last_stall = stall;
        if (stall) n_stall++;
        @(posedge clock);
        #1;
    endtask

    logic mem_busy = 1'b0;
    int   mem_cnt = 0;
    int   op;
    int   waits;

    initial begin
        #2 reset = 1'b0;
        #1;
        check("rst_wb_ir", 32'(wb_ir), 32'h0);
        check("rst_reg_C1", 32'(reg_C1), 32'h0);
        check("rst_d_req", 32'(d_req), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        #20 reset = 1'b1;
        @(posedge clock);
        #1;

        // Pass-through
        run = 1'b1; mem_ir = 16'h1234; reg_C = 16'h00AA;
        tick();
        check("pass_wb_ir", 32'(wb_ir), 32'h1234);
        check("pass_reg_C1", 32'(reg_C1), 32'h00AA);

        // Load acked in the 4th WAIT cycle
        mem_ir = 16'h8001; is_load = 1'b1; reg_C = 16'h0042; n_stall = 0;
        tick();
        check("ld_d_addr", 32'(d_addr), 32'h42);
        check("ld_d_we", 32'(d_we), 32'h0);
        check("ld_bubble", 32'(wb_ir), 32'h0);
        tick(); tick(); tick();
        d_ack = 1'b1; d_rdata = 16'hBEEF;
        tick();
        d_ack = 1'b0; is_load = 1'b0;
        check("ld_reg_C1", 32'(reg_C1), 32'hBEEF);
        check("ld_wb_ir", 32'(wb_ir), 32'h8001);
        check("ld_stall_cycles", 32'(n_stall), 32'd4);

        // Store acked in the first WAIT cycle
        mem_ir = 16'h9002; is_store = 1'b1; reg_C = 16'h0010; smdr1 = 16'h5A5A; n_stall = 0;
        tick();
        check("st_d_we", 32'(d_we), 32'h1);
        check("st_d_wdata", 32'(d_wdata), 32'h5A5A);
        d_ack = 1'b1;
        tick();
        d_ack = 1'b0; is_store = 1'b0;
        check("st_d_we_drop", 32'(d_we), 32'h0);
        check("st_reg_C1", 32'(reg_C1), 32'h0010);
        check("st_wb_ir", 32'(wb_ir), 32'h9002);
        check("st_stall_cycles", 32'(n_stall), 32'd1);

        // Reset in the middle of a WAIT
        mem_ir = 16'h4444; is_load = 1'b1; reg_C = 16'h0055;
        tick(); tick();
        check("rw_d_req", 32'(d_req), 32'h1);
        #2 reset = 1'b0; is_load = 1'b0;
        #1;
        check("rw_d_req_drop", 32'(d_req), 32'h0);
        check("rw_d_we", 32'(d_we), 32'h0);
        check("rw_wb_ir", 32'(wb_ir), 32'h0);
        check("rw_reg_C1", 32'(reg_C1), 32'h0);
        reset = 1'b1;
        d_ack = 1'b1; mem_ir = 16'h4545; reg_C = 16'h0066;
        tick();
        d_ack = 1'b0;
        check("rw_late_ack_d_req", 32'(d_req), 32'h0);
        check("rw_after_wb_ir", 32'(wb_ir), 32'h4545);

`ifdef MEM_TIMEOUT_EN
        mem_ir = 16'h7777; is_load = 1'b1; reg_C = 16'h0033;
        tick();
        waits = 0;
        while (d_req && waits < 20) begin
            tick();
            waits++;
        end
        check("to_wait_cycles", 32'(waits), 32'd8);
        check("to_err", 32'(err), 32'h1);
        check("to_wb_ir", 32'(wb_ir), 32'h0);
        is_load = 1'b0; mem_ir = 16'h1111; reg_C = 16'h2222;
        tick();
        check("to_next_wb_ir", 32'(wb_ir), 32'h1111);
        check("to_next_reg_C1", 32'(reg_C1), 32'h2222);
        check("to_err_sticky", 32'(err), 32'h1);
`endif

        // Random traffic; upstream holds while stalled, memory acks after 1..4 WAIT cycles.
        last_stall = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (d_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_cnt = $urandom_range(0, 3);
                end else if (mem_cnt > 0) begin
                    mem_cnt--;
                end
                d_ack = (mem_cnt == 0);
                d_rdata = DW'($urandom);
            end else begin
                mem_busy = 1'b0;
                d_ack = 1'b0;
            end
            if (!last_stall) begin
                run = ($urandom_range(0, 7) != 0);
                op = $urandom_range(0, 2);
                is_load = (op == 1);
                is_store = (op == 2);
                mem_ir = IW'($urandom);
                reg_C = DW'($urandom);
                smdr1 = DW'($urandom);
            end
            tick();
        end
        d_ack = 1'b0; is_load = 1'b0; is_store = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised memory-access pipeline stage between EX and WB. Passes ALU results straight through in one cycle. For loads and stores it runs a registered request/acknowledge transaction against a variable-latency data memory, and stalls the upstream pipeline until that transaction completes. Width of data, address and instruction word are generics; an optional watchdog aborts hung transactions.

## Interface
- DATA_W, 16, data path width (reg_C, smdr1, d_rdata, d_wdata, reg_C1)
- ADDR_W, 8, data memory address width; must satisfy ADDR_W <= DATA_W
- IR_W, 16, instruction word width
- TIMEOUT, 64, watchdog limit in WAIT cycles; used only with MEM_TIMEOUT_EN; must be >= 2
- clock  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- run  in  1  pipeline execute enable; low freezes the stage in IDLE
- mem_ir  in  IR_W  instruction in MEM; held stable by upstream while stall=1
- is_load  in  1  decoded load
- is_store  in  1  decoded store; is_load and is_store are never both 1
- reg_C  in  DATA_W  ALU result / effective address
- smdr1  in  DATA_W  store data
- d_rdata  in  DATA_W  memory read data, valid when d_ack=1
- d_ack  in  1  memory completion pulse, one cycle, only while d_req=1
- wb_ir  out  IR_W  instruction to WB
- reg_C1  out  DATA_W  result to WB (load data or reg_C)
- d_addr  out  ADDR_W  memory address, registered
- d_wdata  out  DATA_W  store data, registered
- d_we  out  1  write strobe qualifier, registered
- d_req  out  1  request, registered, held until ack
- stall  out  1  combinational; upstream must hold when 1
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, WAIT.
- Reset: state IDLE. wb_ir, reg_C1, d_addr, d_wdata, d_we, d_req, err and the watchdog count all 0.
- IDLE, run=0: all registers hold.
- IDLE, run=1, no access: wb_ir<=mem_ir and reg_C1<=reg_C.
- IDLE, run=1, is_load or is_store (issue):
  - d_req<=1, d_addr<=reg_C[ADDR_W-1:0], d_wdata<=smdr1, d_we<=is_store.
  - wb_ir<=0 (bubble); reg_C1 holds.
  - Next state WAIT.
- WAIT, d_ack=0: outputs hold; watchdog increments. run is ignored in WAIT.
- WAIT, d_ack=1: wb_ir<=mem_ir.
  - Load: reg_C1<=d_rdata.
  - Store: reg_C1<=reg_C.
  - d_req<=0, d_we<=0, watchdog<=0; next state IDLE.
- stall = (IDLE & run & (is_load|is_store)) | (WAIT & ~d_ack).
- d_ack seen in IDLE is ignored.
- Reset asserted mid-transaction: d_req drops immediately. The memory must tolerate an abandoned request.

## Timing
- Pass-through latency: 1 cycle.
- Memory access: the issue cycle, then N >= 1 WAIT cycles. The result appears on wb_ir/reg_C1 on the edge that samples d_ack. Minimum latency is 2 cycles (ack in the first WAIT cycle).
- stall is high from the issue cycle through the last WAIT cycle with d_ack=0. It is low in the ack cycle, so upstream advances on the same edge that retires the access.
- Back-to-back accesses: the next access issues in the cycle after ack. d_req is low for at least 1 cycle between transactions.
- d_addr, d_wdata and d_we stay stable for the whole time d_req=1.

## Configuration
- MEM_TIMEOUT_EN defined:
  - When the watchdog reaches TIMEOUT-1 in WAIT with d_ack=0, the access is aborted: d_req<=0, d_we<=0, err<=1 (sticky until reset), wb_ir<=0 (squashed), reg_C1 holds, state IDLE, stall low in that cycle.
  - A d_ack arriving in the abort cycle is ignored.
- MEM_TIMEOUT_EN undefined: no watchdog logic; WAIT persists until d_ack; err is tied 0.

## Test plan
- Reset with reset=0, then run=1, mem_ir=16'h1234, reg_C=16'h00AA, no access -> one edge later wb_ir=16'h1234, reg_C1=16'h00AA, stall=0 throughout.
- Load, reg_C=16'h0042, memory acks 3 cycles after d_req with d_rdata=16'hBEEF -> d_addr=8'h42, d_we=0, stall high 4 cycles, wb_ir=0 during stall; on ack edge reg_C1=16'hBEEF, wb_ir=mem_ir.
- Store, reg_C=16'h0010, smdr1=16'h5A5A, ack in first WAIT cycle -> d_we=1, d_wdata=16'h5A5A for exactly 1 cycle; reg_C1=16'h0010 after ack; total 2 cycles.
- Back-to-back load then store -> d_req deasserts for exactly 1 cycle between them; both results retire in order; stall=0 in both ack cycles.
- Reset pulsed while in WAIT with d_req=1 -> d_req, d_we, wb_ir and reg_C1 are 0 immediately; a late d_ack after reset is ignored.
- MEM_TIMEOUT_EN, TIMEOUT=8, memory never acks -> d_req drops after 8 WAIT cycles, err=1 and stays 1, wb_ir=0, stall=0; the next non-memory instruction passes through normally.
